// File: rtl/serial_divider.sv
// Serial restoring divider: one quotient bit per clock, MSB first.
// A 2*W-bit dividend divided by a W-bit divisor gives a 2*W-bit quotient and a W-bit remainder.
// A zero divisor skips the iteration and reports an all-ones quotient with dbz set.
module serial_divider #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic [2*W-1:0] q,
  output logic [W-1:0]   r,
  output logic           busy,
  output logic           done,
  output logic           dbz
);

  // The counter is one bit wider than 2*W-1 needs, so it can never wrap at the last step.
  localparam int CW = $clog2(2*W) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(2*W-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r, state_next_s;
  logic [2*W-1:0] dvd_r, quo_r, quo_next_s;
  logic [W-1:0]   dvs_r;
  logic [W:0]     rem_r, rem_shift_s, rem_next_s;
  logic [CW-1:0]  cnt_r;
  logic           qbit_s, last_s, accept_s, zero_s;

  // One restoring step: bring in the next dividend bit and subtract the divisor if it fits.
  always_comb begin
    rem_shift_s = (rem_r << 1) | {{W{1'b0}}, dvd_r[2*W-1]};
    if (rem_shift_s >= {1'b0, dvs_r}) begin
      rem_next_s = rem_shift_s - {1'b0, dvs_r};
      qbit_s     = 1'b1;
    end else begin
      rem_next_s = rem_shift_s;
      qbit_s     = 1'b0;
    end
    quo_next_s = (quo_r << 1) | {{(2*W-1){1'b0}}, qbit_s};
    last_s     = (cnt_r == LAST_STEP);
    accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
    zero_s     = (divisor == {W{1'b0}});
  end

  // Next-state logic: a new request is accepted from IDLE or from the DONE cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = zero_s ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_next_s = zero_s ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath, results and status flags; busy/done are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_r <= {(2*W){1'b0}};
      dvs_r <= {W{1'b0}};
      rem_r <= {(W+1){1'b0}};
      quo_r <= {(2*W){1'b0}};
      cnt_r <= {CW{1'b0}};
      q     <= {(2*W){1'b0}};
      r     <= {W{1'b0}};
      dbz   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (accept_s) begin
        dvd_r <= dividend;
        dvs_r <= divisor;
        rem_r <= {(W+1){1'b0}};
        quo_r <= {(2*W){1'b0}};
        cnt_r <= {CW{1'b0}};
        if (zero_s) begin
          q   <= {(2*W){1'b1}};
          r   <= {W{1'b0}};
          dbz <= 1'b1;
        end
      end else if (state_r == RUN) begin
        dvd_r <= dvd_r << 1;
        rem_r <= rem_next_s;
        quo_r <= quo_next_s;
        if (last_s) begin
          q   <= quo_next_s;
          r   <= rem_next_s[W-1:0];
          dbz <= 1'b0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
      busy <= (state_next_s == RUN);
      done <= (state_next_s == DONE);
    end
  end

endmodule

// File: tb/tb_serial_divider.sv
// Directed and exhaustive self-checking bench for serial_divider (W=4).
// Inputs are driven and outputs sampled on the falling clock edge.
// A normal division keeps busy high for 8 cycles; done shows up in the 9th
// cycle after the accepting edge. Divide-by-zero shows done in the 1st cycle.
module tb_serial_divider;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] dividend, q;
  logic [3:0] divisor, r;
  logic       busy, done, dbz;
  int         checks = 0;
  int         errors = 0;

  serial_divider #(.W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .q(q), .r(r), .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // Drives one request and waits (bounded) for done. Reports the cycle index
  // where done was seen, busy cycle count, busy&done overlap and whether the
  // previous results stayed untouched while the division ran.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int glitch_at,
                        output int lat, output int bcnt, output bit overlap, output bit held);
    logic [7:0] q0;
    logic [3:0] r0;
    logic       d0;
    q0 = q; r0 = r; d0 = dbz;
    held = 1'b1; overlap = 1'b0; bcnt = 0;
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin
      if (busy) bcnt++;
      if (q !== q0 || r !== r0 || dbz !== d0) held = 1'b0;
      if (lat == glitch_at) begin
        start = 1'b1; dividend = 8'd255; divisor = 4'd1;
      end else if (lat == glitch_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    if (busy && done) overlap = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
    #1;
    checks++;
    if ({q, r, busy, done, dbz} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b, want all 0", q, r, busy, done, dbz);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    int lat, bcnt; bit ov, held;
    run_op(8'd200, 4'd7, -1, lat, bcnt, ov, held);
    checks++;
    if (q !== 8'd28 || r !== 4'd4 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%0b, want q=28 r=4 dbz=0", q, r, dbz);
    end
    checks++;
    if (lat !== 9 || bcnt !== 8) begin
      errors++;
      $display("FAIL basic_timing: got done_cycle=%0d busy_cycles=%0d, want 9 and 8", lat, bcnt);
    end
    checks++;
    if (ov !== 1'b0) begin
      errors++;
      $display("FAIL basic_overlap: got busy&done=%0b, want 0", ov);
    end
  endtask

  task automatic test_hold;
    repeat (3) @(negedge clk);
    checks++;
    if (q !== 8'd28 || r !== 4'd4 || dbz !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got q=%0d r=%0d dbz=%0b busy=%0b done=%0b, want 28 4 0 0 0", q, r, dbz, busy, done);
    end
  endtask

  task automatic test_corners;
    logic [7:0] a_t [4] = '{8'd255, 8'd5, 8'd0, 8'd255};
    logic [3:0] b_t [4] = '{4'd1, 4'd9, 4'd3, 4'd15};
    logic [7:0] q_t [4] = '{8'd255, 8'd0, 8'd0, 8'd17};
    logic [3:0] r_t [4] = '{4'd0, 4'd5, 4'd0, 4'd0};
    int lat, bcnt; bit ov, held;
    for (int i = 0; i < 4; i++) begin
      run_op(a_t[i], b_t[i], -1, lat, bcnt, ov, held);
      checks++;
      if (q !== q_t[i] || r !== r_t[i] || lat !== 9 || !held) begin
        errors++;
        $display("FAIL corner_%0d: got q=%0d r=%0d done_cycle=%0d held=%0b, want q=%0d r=%0d 9 1",
                 i, q, r, lat, held, q_t[i], r_t[i]);
      end
    end
  endtask

  task automatic test_dbz;
    int lat, bcnt; bit ov, held;
    run_op(8'd77, 4'd0, -1, lat, bcnt, ov, held);
    checks++;
    if (q !== 8'd255 || r !== 4'd0 || dbz !== 1'b1 || lat !== 1 || bcnt !== 0) begin
      errors++;
      $display("FAIL dbz: got q=%0d r=%0d dbz=%0b done_cycle=%0d busy_cycles=%0d, want 255 0 1 1 0", q, r, dbz, lat, bcnt);
    end
    run_op(8'd77, 4'd7, -1, lat, bcnt, ov, held);
    checks++;
    if (q !== 8'd11 || r !== 4'd0 || dbz !== 1'b0 || lat !== 9) begin
      errors++;
      $display("FAIL after_dbz: got q=%0d r=%0d dbz=%0b done_cycle=%0d, want 11 0 0 9", q, r, dbz, lat);
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL run_hold: got held=%0b, want 1 (q=255 dbz=1 kept during run)", held);
    end
  endtask

  task automatic test_start_during_busy;
    int lat, bcnt; bit ov, held;
    @(negedge clk);
    run_op(8'd100, 4'd9, 3, lat, bcnt, ov, held);
    checks++;
    if (q !== 8'd11 || r !== 4'd1 || lat !== 9 || bcnt !== 8) begin
      errors++;
      $display("FAIL start_in_busy: got q=%0d r=%0d done_cycle=%0d busy_cycles=%0d, want 11 1 9 8", q, r, lat, bcnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_single: got done=%0b busy=%0b, want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt; bit ov, held;
    run_op(8'd200, 4'd7, -1, lat, bcnt, ov, held);
    run_op(8'd100, 4'd3, -1, lat, bcnt, ov, held);
    checks++;
    if (q !== 8'd33 || r !== 4'd1 || lat !== 9 || ov !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: got q=%0d r=%0d done_cycle=%0d overlap=%0b, want 33 1 9 0", q, r, lat, ov);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt; bit ov, held;
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({q, r, busy, done, dbz} !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b, want all 0", q, r, busy, done, dbz);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_%0d: got done=%0b busy=%0b, want 0 0", i, done, busy);
      end
    end
    rst = 1'b1;
    run_op(8'd50, 4'd6, -1, lat, bcnt, ov, held);
    checks++;
    if (q !== 8'd8 || r !== 4'd2 || dbz !== 1'b0 || lat !== 9) begin
      errors++;
      $display("FAIL after_reset: got q=%0d r=%0d dbz=%0b done_cycle=%0d, want 8 2 0 9", q, r, dbz, lat);
    end
  endtask

  task automatic test_exhaustive;
    int lat, bcnt; bit ov, held;
    logic [7:0] eq;
    logic [3:0] er;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        eq = 8'(a / b);
        er = 4'(a % b);
        run_op(8'(a), 4'(b), -1, lat, bcnt, ov, held);
        checks++;
        if (q !== eq || r !== er || dbz !== 1'b0 || lat !== 9 || ov !== 1'b0) begin
          errors++;
          $display("FAIL exhaustive %0d/%0d: got q=%0d r=%0d dbz=%0b done_cycle=%0d, want q=%0d r=%0d dbz=0 9",
                   a, b, q, r, dbz, lat, eq, er);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_corners;
    test_dbz;
    test_start_during_busy;
    test_back_to_back;
    test_reset_mid;
    test_exhaustive;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
